// File: rtl/mp_addsub_iter.sv
// Iterative multi-precision adder/subtractor: one LIMB-bit slice per cycle,
// carry/borrow rippled through a register, (WIDTH+1)-bit two's-complement result.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             request, sampled only while idle
//   op[1:0]           00 A+B+cin, 01 A-B-cin, 10 B-A-cin, 11 as 00
//   cin               carry-in (add) / borrow-in (subtract)
//   in_a, in_b        WIDTH-bit unsigned operands
//   result            result mod 2^(WIDTH+1), held until the next completion
//   zero              result == 0
//   busy              operation in progress
//   done              one-cycle pulse when result/zero update
module mp_addsub_iter #(
   parameter int WIDTH = 1027,
   parameter int LIMB  = 257
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             cin,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   // ceil((WIDTH+1)/LIMB)
   localparam int NLIMBS = (WIDTH + LIMB) / LIMB;
   localparam int PW     = NLIMBS * LIMB;
   localparam int KW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NLIMBS - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [PW-1:0]    a_q, a_d;
   logic [PW-1:0]    b_q, b_d;
   logic [PW-1:0]    sr_q, sr_d;
   logic             carry_q, carry_d;
   logic             zacc_q, zacc_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   logic [LIMB:0]    sum;
   logic [PW-1:0]    sr_nxt;
   logic [LIMB-1:0]  lmask;
   logic [PW-1:0]    a_ext, b_ext, x_ext, y_ext;
   logic             sub;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      sr_d     = sr_q;
      carry_d  = carry_q;
      zacc_d   = zacc_q;
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;

      a_ext = PW'(in_a);
      b_ext = PW'(in_b);
      sub   = (op == 2'b01) || (op == 2'b10);
      // Reverse subtraction is plain subtraction with the operands swapped.
      x_ext = (op == 2'b10) ? b_ext : a_ext;
      y_ext = (op == 2'b10) ? a_ext : b_ext;

      sum = {1'b0, a_q[LIMB-1:0]}
          + {1'b0, b_q[LIMB-1:0]}
          + (LIMB+1)'(carry_q);

      // Limbs enter at the top, so limb 0 ends at the bottom after NLIMBS shifts.
      sr_nxt = (sr_q >> LIMB) | (PW'(sum[LIMB-1:0]) << (PW - LIMB));

      // Only bits 0..WIDTH of the assembled word contribute to the zero flag.
      for (int i = 0; i < LIMB; i++) begin
         lmask[i] = ((int'(k_q) * LIMB + i) <= WIDTH);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = x_ext;
               // A - B - cin == A + ~B + ~cin (mod 2^PW)
               b_d     = sub ? ~y_ext : y_ext;
               carry_d = cin ^ sub;
               k_d     = '0;
               zacc_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> LIMB;
            b_d     = b_q >> LIMB;
            carry_d = sum[LIMB];
            sr_d    = sr_nxt;
            zacc_d  = zacc_q & ~|(sum[LIMB-1:0] & lmask);
            k_d     = k_q + 1'b1;
            if (k_q == KLAST) begin
               result_d = sr_nxt[WIDTH:0];
               zero_d   = zacc_d;
               done_d   = 1'b1;
               k_d      = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sr_q     <= '0;
         carry_q  <= 1'b0;
         zacc_q   <= 1'b1;
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sr_q     <= sr_d;
         carry_q  <= carry_d;
         zacc_q   <= zacc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign busy   = (state_q == RUN);
   assign done   = done_q;

endmodule
